// File: rtl/bip_control.sv
// bip_control: control unit of the accumulator processor.
//
// Sequences IDLE -> FETCH -> LOAD_IR -> EXEC [-> WB] -> FETCH ... and stops in
// HALTED on an HLT instruction. Every control output comes from a flop, so the
// outputs are glitch-free and drop to 0 at once when the reset is asserted.
//
// Ports:
//   i_clock   system clock, rising edge
//   i_reset   asynchronous active-low reset
//   i_start   level, leaves IDLE when high
//   i_instr   program ROM data (synchronous ROM, valid the cycle after o_rd_rom)
//   o_pc_addr program ROM address (current PC)
//   o_rd_rom  program ROM read enable
//   o_operand IR operand field (RAM address / immediate)
//   o_sel_A   accumulator source: 0 RAM, 1 immediate, 2 ALU, 3 reserved
//   o_sel_B   ALU B source: 0 RAM, 1 immediate
//   o_op      ALU op: 0 add, 1 subtract
//   o_w_acc   accumulator write enable
//   o_wr_ram  data RAM write strobe
//   o_rd_ram  data RAM read enable
//   o_halt    high while halted
//   o_cycles  execution cycle count
module bip_control #(
    parameter int PC_BITS = 11,
    parameter int I_BITS  = 16,
    parameter int D_BITS  = 11,
    parameter int S_BITS  = 2,
    parameter int C_BITS  = 32
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_start,
    input  logic [I_BITS-1:0]  i_instr,
    output logic [PC_BITS-1:0] o_pc_addr,
    output logic               o_rd_rom,
    output logic [D_BITS-1:0]  o_operand,
    output logic [S_BITS-1:0]  o_sel_A,
    output logic               o_sel_B,
    output logic               o_op,
    output logic               o_w_acc,
    output logic               o_wr_ram,
    output logic               o_rd_ram,
    output logic               o_halt,
    output logic [C_BITS-1:0]  o_cycles
);

    localparam int OPC_W = I_BITS - D_BITS;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_FETCH   = 3'd1;
    localparam logic [2:0] S_LOAD_IR = 3'd2;
    localparam logic [2:0] S_EXEC    = 3'd3;
    localparam logic [2:0] S_WB      = 3'd4;
    localparam logic [2:0] S_HALTED  = 3'd5;

    localparam logic [OPC_W-1:0] OP_HLT  = OPC_W'(0);
    localparam logic [OPC_W-1:0] OP_STO  = OPC_W'(1);
    localparam logic [OPC_W-1:0] OP_LD   = OPC_W'(2);
    localparam logic [OPC_W-1:0] OP_LDI  = OPC_W'(3);
    localparam logic [OPC_W-1:0] OP_ADD  = OPC_W'(4);
    localparam logic [OPC_W-1:0] OP_ADDI = OPC_W'(5);
    localparam logic [OPC_W-1:0] OP_SUB  = OPC_W'(6);
    localparam logic [OPC_W-1:0] OP_SUBI = OPC_W'(7);

    localparam logic [S_BITS-1:0] SEL_A_RAM = S_BITS'(0);
    localparam logic [S_BITS-1:0] SEL_A_IMM = S_BITS'(1);
    localparam logic [S_BITS-1:0] SEL_A_ALU = S_BITS'(2);

    localparam logic [PC_BITS-1:0] PC_ONE  = PC_BITS'(1);
    localparam logic [C_BITS-1:0]  CYC_ONE = C_BITS'(1);

    logic [2:0]         state_q,  state_d;
    logic [PC_BITS-1:0] pc_q,     pc_d;
    logic [I_BITS-1:0]  ir_q,     ir_d;
    logic [C_BITS-1:0]  cycles_q, cycles_d;
    logic               rd_rom_q, rd_rom_d;
    logic [S_BITS-1:0]  sel_a_q,  sel_a_d;
    logic               sel_b_q,  sel_b_d;
    logic               op_q,     op_d;
    logic               w_acc_q,  w_acc_d;
    logic               wr_ram_q, wr_ram_d;
    logic               rd_ram_q, rd_ram_d;
    logic               halt_q,   halt_d;

    logic [OPC_W-1:0]   opc_q;    // opcode of the instruction being executed
    logic [OPC_W-1:0]   opc_d;    // opcode that will be in IR next cycle

    assign opc_q = ir_q[I_BITS-1:D_BITS];
    assign opc_d = ir_d[I_BITS-1:D_BITS];

    // Next state, PC, IR and cycle counter.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ir_d     = ir_q;
        cycles_d = cycles_q;
        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    state_d = S_FETCH;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_FETCH: begin
                state_d = S_LOAD_IR;
            end
            S_LOAD_IR: begin
                ir_d    = i_instr;
                pc_d    = pc_q + PC_ONE;
                state_d = S_EXEC;
            end
            S_EXEC: begin
                case (opc_q)
                    OP_HLT:                state_d = S_HALTED;
                    OP_LD, OP_ADD, OP_SUB: state_d = S_WB;
                    default:               state_d = S_FETCH;
                endcase
            end
            S_WB: begin
                state_d = S_FETCH;
            end
            S_HALTED: begin
                state_d = S_HALTED;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        // Only active execution is counted; the edge leaving IDLE is not.
        if ((state_q != S_IDLE) && (state_q != S_HALTED)) begin
            cycles_d = cycles_q + CYC_ONE;
        end else begin
            cycles_d = cycles_q;
        end
    end

    // Control decode for the state being entered, so the output flops line up
    // with state_q and IR in the same cycle.
    always_comb begin
        rd_rom_d = 1'b0;
        sel_a_d  = SEL_A_RAM;
        sel_b_d  = 1'b0;
        op_d     = 1'b0;
        w_acc_d  = 1'b0;
        wr_ram_d = 1'b0;
        rd_ram_d = 1'b0;
        halt_d   = 1'b0;
        case (state_d)
            S_FETCH: begin
                rd_rom_d = 1'b1;
            end
            S_EXEC: begin
                case (opc_d)
                    OP_STO: begin
                        wr_ram_d = 1'b1;
                    end
                    OP_LD, OP_ADD, OP_SUB: begin
                        rd_ram_d = 1'b1;
                    end
                    OP_LDI: begin
                        sel_a_d = SEL_A_IMM;
                        w_acc_d = 1'b1;
                    end
                    OP_ADDI: begin
                        sel_b_d = 1'b1;
                        sel_a_d = SEL_A_ALU;
                        w_acc_d = 1'b1;
                    end
                    OP_SUBI: begin
                        sel_b_d = 1'b1;
                        op_d    = 1'b1;
                        sel_a_d = SEL_A_ALU;
                        w_acc_d = 1'b1;
                    end
                    default: begin
                        w_acc_d = 1'b0;
                    end
                endcase
            end
            S_WB: begin
                case (opc_d)
                    OP_LD: begin
                        sel_a_d = SEL_A_RAM;
                        w_acc_d = 1'b1;
                    end
                    OP_ADD: begin
                        sel_a_d = SEL_A_ALU;
                        w_acc_d = 1'b1;
                    end
                    OP_SUB: begin
                        op_d    = 1'b1;
                        sel_a_d = SEL_A_ALU;
                        w_acc_d = 1'b1;
                    end
                    default: begin
                        w_acc_d = 1'b0;
                    end
                endcase
            end
            S_HALTED: begin
                halt_d = 1'b1;
            end
            default: begin
                halt_d = 1'b0;
            end
        endcase
    end

    // State, PC, IR, counter and registered control outputs.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state_q  <= S_IDLE;
            pc_q     <= '0;
            ir_q     <= '0;
            cycles_q <= '0;
            rd_rom_q <= 1'b0;
            sel_a_q  <= SEL_A_RAM;
            sel_b_q  <= 1'b0;
            op_q     <= 1'b0;
            w_acc_q  <= 1'b0;
            wr_ram_q <= 1'b0;
            rd_ram_q <= 1'b0;
            halt_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            cycles_q <= cycles_d;
            rd_rom_q <= rd_rom_d;
            sel_a_q  <= sel_a_d;
            sel_b_q  <= sel_b_d;
            op_q     <= op_d;
            w_acc_q  <= w_acc_d;
            wr_ram_q <= wr_ram_d;
            rd_ram_q <= rd_ram_d;
            halt_q   <= halt_d;
        end
    end

    assign o_pc_addr = pc_q;
    assign o_rd_rom  = rd_rom_q;
    assign o_operand = ir_q[D_BITS-1:0];
    assign o_sel_A   = sel_a_q;
    assign o_sel_B   = sel_b_q;
    assign o_op      = op_q;
    assign o_w_acc   = w_acc_q;
    assign o_wr_ram  = wr_ram_q;
    assign o_rd_ram  = rd_ram_q;
    assign o_halt    = halt_q;
    assign o_cycles  = cycles_q;

endmodule
